// File: rtl/sensor_pkt_pkg.sv
// Shared definitions for the sensor packet builder: packet byte layout,
// flag bit positions, the IMU sample record and the builder FSM states.
package sensor_pkt_pkg;

    localparam int PKT_BYTES    = 32;
    localparam int SAMPLE_BYTES = 12;

    // Byte offsets inside the 32-byte packet (byte 0 goes out first).
    localparam int HDR_OFS  = 0;
    localparam int SEQ_OFS  = 1;
    localparam int FLAG_OFS = 2;
    localparam int TS_OFS   = 3;   // timestamp, big-endian, 2 bytes
    localparam int S0_OFS   = 5;   // sensor0 sample, big-endian, 12 bytes
    localparam int S1_OFS   = 17;  // sensor1 sample, big-endian, 12 bytes
    localparam int PAD_OFS  = 29;  // two zero bytes
    localparam int CSUM_OFS = 31;  // XOR of bytes 0..30

    // Bit positions inside the flags byte.
    localparam int FLAG_FRESH0 = 0;
    localparam int FLAG_FRESH1 = 1;
    localparam int FLAG_OVF    = 7;

    // ax occupies the most significant 16 bits of the 96-bit sample word.
    typedef struct packed {
        logic signed [15:0] ax;
        logic signed [15:0] ay;
        logic signed [15:0] az;
        logic signed [15:0] gx;
        logic signed [15:0] gy;
        logic signed [15:0] gz;
    } imu_sample_t;

    typedef enum logic [1:0] {
        COLLECT,
        FREEZE,
        CSUM,
        HOLD
    } state_t;

    // Byte i (0 = most significant) of a sample, for big-endian packing.
    function automatic logic [7:0] sample_byte(input imu_sample_t s, input int i);
        logic [95:0] v;
        v = s >> (8 * (11 - i));
        return v[7:0];
    endfunction

endpackage

// File: rtl/sensor_sample_stage.sv
// One-deep staging register for a single IMU.
//   clk, reset : clock, asynchronous active-high reset
//   valid, data: 1-cycle strobe with a new 96-bit sample
//   take       : builder is copying the stage into a packet this cycle
//   sample     : latest sample ever received (stale copy when not fresh)
//   fresh      : sample not yet placed into a packet
//   overwrite  : a fresh, unsent sample is being replaced this cycle
module sensor_sample_stage
    import sensor_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [95:0] data,
    input  logic        take,
    output imu_sample_t sample,
    output logic        fresh,
    output logic        overwrite
);

    // A strobe coinciding with take is not an overrun: the old sample is
    // being consumed in the same cycle the new one lands.
    assign overwrite = valid & fresh & ~take;

    // A strobe wins over take, so the new sample stays marked fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample <= '0;
            fresh  <= 1'b0;
        end else if (valid) begin
            sample <= imu_sample_t'(data);
            fresh  <= 1'b1;
        end else if (take) begin
            fresh  <= 1'b0;
        end
    end

endmodule

// File: rtl/sensor_packet_builder.sv
// Builds a 32-byte packet from the latest samples of two IMUs and offers it
// to the downstream SPI slave.
//   clk, reset          : clock, asynchronous active-high reset
//   s0_valid, s0_data   : sensor0 strobe and sample {ax,ay,az,gx,gy,gz}
//   s1_valid, s1_data   : sensor1 strobe and sample
//   data_bytes[0:31]    : packet, byte 0 first on the wire
//   data_ready          : packet valid and stable
//   data_ack            : 1-cycle pulse, packet consumed
//   overrun             : sticky, a staged sample was overwritten unsent
//
// Handshake: data_ready is high only in HOLD and is masked by data_ack in the
// same cycle, so the slave sees it drop the moment it acknowledges and never
// captures the old packet twice. data_bytes do not change while data_ready is
// high; data_ack outside HOLD has no effect.
module sensor_packet_builder
    import sensor_pkt_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 48000,
    parameter int          TICK_DIV       = 48,
    parameter logic [7:0]  HEADER_BYTE    = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s0_valid,
    input  logic [95:0] s0_data,
    input  logic        s1_valid,
    input  logic [95:0] s1_data,
    output logic [7:0]  data_bytes [0:PKT_BYTES-1],
    output logic        data_ready,
    input  logic        data_ack,
    output logic        overrun
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_DIV - 1);
    localparam logic [4:0]      IDX_LAST  = 5'd31;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TK_W-1:0]  tick_cnt_q;
    logic [15:0]      ts_q;
    logic [7:0]       seq_q;
    logic [7:0]       acc_q;
    logic [4:0]       idx_q;
    logic             ovf_pend_q;
    logic             overrun_q;
    logic [7:0]       flags;
    logic             to_last;
    logic             take;

    imu_sample_t      s0_sample, s1_sample;
    logic             fresh0, fresh1;
    logic             ovf0, ovf1;

    assign take    = (state_q == FREEZE);
    assign to_last = (to_cnt_q == TO_LAST);

    sensor_sample_stage u_stage0 (
        .clk       (clk),
        .reset     (reset),
        .valid     (s0_valid),
        .data      (s0_data),
        .take      (take),
        .sample    (s0_sample),
        .fresh     (fresh0),
        .overwrite (ovf0)
    );

    sensor_sample_stage u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .valid     (s1_valid),
        .data      (s1_data),
        .take      (take),
        .sample    (s1_sample),
        .fresh     (fresh1),
        .overwrite (ovf1)
    );

    always_comb begin
        flags              = '0;
        flags[FLAG_OVF]    = ovf_pend_q;
        flags[FLAG_FRESH1] = fresh1;
        flags[FLAG_FRESH0] = fresh0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    // CSUM spends idx 0..30 accumulating and idx 31 writing the checksum,
    // giving 33 cycles from FREEZE entry to data_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if ((fresh0 && fresh1) || (to_last && (fresh0 || fresh1)))
                         state_d = FREEZE;
            FREEZE:  state_d = CSUM;
            CSUM:    if (idx_q == IDX_LAST) state_d = HOLD;
            HOLD:    if (data_ack) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    assign data_ready = (state_q == HOLD) & ~data_ack;
    assign overrun    = overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q   <= '0;
            tick_cnt_q <= '0;
            ts_q       <= '0;
            seq_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            ovf_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < PKT_BYTES; i++) data_bytes[i] <= '0;
        end else begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_q <= '0;
                ts_q       <= ts_q + 16'd1;
            end else begin
                tick_cnt_q <= tick_cnt_q + TK_W'(1);
            end

            if (ovf0 || ovf1) begin
                ovf_pend_q <= 1'b1;
                overrun_q  <= 1'b1;
            end

            case (state_q)
                COLLECT: to_cnt_q <= to_last ? '0 : to_cnt_q + TO_W'(1);
                FREEZE: begin
                    data_bytes[HDR_OFS]    <= HEADER_BYTE;
                    data_bytes[SEQ_OFS]    <= seq_q;
                    data_bytes[FLAG_OFS]   <= flags;
                    data_bytes[TS_OFS]     <= ts_q[15:8];
                    data_bytes[TS_OFS + 1] <= ts_q[7:0];
                    for (int i = 0; i < SAMPLE_BYTES; i++) begin
                        data_bytes[S0_OFS + i] <= sample_byte(s0_sample, i);
                        data_bytes[S1_OFS + i] <= sample_byte(s1_sample, i);
                    end
                    data_bytes[PAD_OFS]     <= 8'h00;
                    data_bytes[PAD_OFS + 1] <= 8'h00;
                    // No overwrite can occur in FREEZE (take masks it), so
                    // this clear never loses a new overrun.
                    ovf_pend_q <= 1'b0;
                    acc_q      <= '0;
                    idx_q      <= '0;
                end
                CSUM: begin
                    if (idx_q == IDX_LAST) data_bytes[CSUM_OFS] <= acc_q;
                    else                   acc_q <= acc_q ^ data_bytes[idx_q];
                    idx_q <= idx_q + 5'd1;
                end
                HOLD: if (data_ack) begin
                    seq_q    <= seq_q + 8'd1;
                    to_cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_packet_builder.sv
module tb_sensor_packet_builder;

  localparam int T_OUT = 100;
  localparam int T_DIV = 1;
  localparam logic [7:0] HDR = 8'hAA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [95:0] s0_data = '0, s1_data = '0;
  logic [7:0]  data_bytes [0:31];
  logic        data_ready, overrun;
  logic        mon_ack = 1'b0, drv_ack = 1'b0;
  logic        data_ack;
  assign data_ack = mon_ack | drv_ack;

  sensor_packet_builder #(
    .TIMEOUT_CYCLES (T_OUT),
    .TICK_DIV       (T_DIV),
    .HEADER_BYTE    (HDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s0_valid   (s0_valid),
    .s0_data    (s0_data),
    .s1_valid   (s1_valid),
    .s1_data    (s1_data),
    .data_bytes (data_bytes),
    .data_ready (data_ready),
    .data_ack   (data_ack),
    .overrun    (overrun)
  );

  // clock edges since reset release (edge 1 is the first one after release)
  int unsigned cyc;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [255:0] pack_bytes();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[255-8*i -: 8] = data_bytes[i];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [255:0] exp_q[$];
  int unsigned  exp_rdy_q[$];
  logic         exp_ovr_q[$];
  int           hold_q[$];
  int unsigned  pushed = 0, acked = 0, last_ack = 0;
  bit           presenting = 1'b0;

  // ---------------- reference model ----------------
  logic [95:0] m_stage [2];
  bit          m_fresh [2];
  bit          m_ovf_pend, m_ovr;
  logic [7:0]  m_seq;
  bit          have_first, have_both;
  int unsigned first_e, both_e;

  task automatic model_reset();
    m_stage[0] = '0; m_stage[1] = '0;
    m_fresh[0] = 0;  m_fresh[1] = 0;
    m_ovf_pend = 0;  m_ovr = 0; m_seq = 8'h00;
    have_first = 0;  have_both = 0;
    last_ack = 0;
  endtask

  task automatic model_strobe(input int s, input logic [95:0] d, input int unsigned e);
    if (m_fresh[s]) begin
      m_ovf_pend = 1;
      m_ovr = 1;
    end
    m_stage[s] = d;
    m_fresh[s] = 1;
    if (!have_first) begin have_first = 1; first_e = e; end
    if (m_fresh[0] && m_fresh[1] && !have_both) begin have_both = 1; both_e = e; end
  endtask

  // Edge at which FREEZE is entered: one edge after both sensors are fresh,
  // or at the first timeout boundary (multiple of T_OUT after the last ack)
  // following the first fresh sample, whichever comes first.
  function automatic int unsigned compute_f();
    int unsigned fb, ft, e1, j;
    fb = 32'hFFFF_FFFF;
    ft = 32'hFFFF_FFFF;
    if (have_both) fb = ((both_e > last_ack) ? both_e : last_ack) + 1;
    if (have_first) begin
      e1 = (first_e > last_ack) ? first_e : last_ack;
      j  = (e1 + 1 - last_ack + T_OUT - 1) / T_OUT;
      ft = last_ack + j * T_OUT;
    end
    return (fb < ft) ? fb : ft;
  endfunction

  task automatic build_push(input int unsigned f, input int hold);
    logic [7:0]   b [32];
    logic [15:0]  ts;
    logic [7:0]   x;
    logic [255:0] v;
    ts   = 16'((f / T_DIV) % 65536);
    b[0] = HDR;
    b[1] = m_seq;
    b[2] = {m_ovf_pend, 5'b0, m_fresh[1], m_fresh[0]};
    b[3] = ts[15:8];
    b[4] = ts[7:0];
    for (int i = 0; i < 12; i++) begin
      b[5+i]  = m_stage[0][95-8*i -: 8];
      b[17+i] = m_stage[1][95-8*i -: 8];
    end
    b[29] = 8'h00;
    b[30] = 8'h00;
    x = 8'h00;
    for (int i = 0; i < 31; i++) x = x ^ b[i];
    b[31] = x;
    for (int i = 0; i < 32; i++) v[255-8*i -: 8] = b[i];
    exp_q.push_back(v);
    exp_rdy_q.push_back(f + 33);
    exp_ovr_q.push_back(m_ovr);
    hold_q.push_back(hold);
    pushed++;
    m_fresh[0] = 0; m_fresh[1] = 0;
    m_ovf_pend = 0;
    m_seq      = m_seq + 8'd1;
    have_first = 0; have_both = 0;
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // called at a negedge; the strobe is sampled on the next posedge
  task automatic strobe(input int s, input logic [95:0] d);
    model_strobe(s, d, cyc + 1);
    if (s == 0) begin s0_valid = 1; s0_data = d; end
    else        begin s1_valid = 1; s1_data = d; end
    @(negedge clk);
    s0_valid = 0;
    s1_valid = 0;
  endtask

  task automatic wait_acked();
    for (int k = 0; k < 5000 && acked < pushed; k++) @(negedge clk);
    if (acked < pushed) begin
      checks++;
      failures++;
      $display("FAIL ack_wait: got acked=%0d expected acked=%0d", acked, pushed);
      finish_now();
    end
  endtask

  task automatic pkt_both(input int f, input int n, input int hold, input logic [95:0] d0, input logic [95:0] d1, input bit use_d);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      strobe(f, (use_d && k == n - 1) ? ((f == 0) ? d0 : d1) : rand96());
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    strobe(1 - f, use_d ? ((f == 0) ? d1 : d0) : rand96());
    build_push(compute_f(), hold);
  endtask

  task automatic pkt_single(input int s, input int n, input int hold);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      strobe(s, rand96());
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    build_push(compute_f(), hold);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [255:0] held, act;
    logic         exp_ovr;
    int unsigned  exp_rdy;
    int           hold;
    bit           unstable;
    forever begin
      @(negedge clk);
      if (!reset && data_ready) begin
        act = pack_bytes();
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ready: got data_ready=1 at cycle %0d expected 0", cyc);
          hold = 0;
        end else begin
          held    = exp_q.pop_front();
          exp_rdy = exp_rdy_q.pop_front();
          exp_ovr = exp_ovr_q.pop_front();
          hold    = hold_q.pop_front();
          check("latency", cyc, exp_rdy);
          check("packet", act, held);
          check("overrun", overrun, exp_ovr);
        end
        presenting = 1;
        unstable   = 0;
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          if (pack_bytes() !== act || data_ready !== 1'b1) unstable = 1;
        end
        check("hold_stable", unstable, 1'b0);
        mon_ack = 1;
        #1;
        check("ack_mask", data_ready, 1'b0);
        last_ack = cyc + 1;
        @(negedge clk);
        mon_ack    = 0;
        presenting = 0;
        acked++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    checks++;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_now();
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned f;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ready", data_ready, 1'b0);
    check("reset_bytes", pack_bytes(), 256'h0);
    check("reset_overrun", overrun, 1'b0);
    reset = 0;
    repeat (2) @(negedge clk);

    // both sensors, fixed data; an ack pulse during CSUM must be ignored
    pkt_both(0, 1, 1, 96'h0001_0002_0003_0004_0005_0006,
             96'h1111_2222_3333_4444_5555_6666, 1);
    f = exp_rdy_q[0] - 33;
    for (int k = 0; k < 100 && cyc < f + 5; k++) @(negedge clk);
    drv_ack = 1;
    @(negedge clk);
    drv_ack = 0;
    wait_acked();

    // sensor0 only: emitted at the timeout with a stale sensor1 copy
    pkt_single(0, 1, 0);
    wait_acked();

    // three sensor0 strobes before sensor1: overwrite flagged, latest kept
    pkt_both(0, 3, 0, '0, '0, 0);
    wait_acked();
    pkt_both($urandom_range(0, 1), 1, 2, '0, '0, 0);
    wait_acked();

    // long hold with new samples staged meanwhile
    pkt_both(1, 1, 1000, '0, '0, 0);
    for (int k = 0; k < 500 && !presenting; k++) @(negedge clk);
    repeat (100) @(negedge clk);
    strobe(0, rand96());
    repeat (50) @(negedge clk);
    strobe(1, rand96());
    wait_acked();
    build_push(compute_f(), 1);
    wait_acked();

    // random traffic, enough packets to wrap the sequence number
    while (pushed < 258) begin
      if ($urandom_range(0, 4) == 0) pkt_single($urandom_range(0, 1), $urandom_range(1, 2), $urandom_range(0, 3));
      else pkt_both($urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(0, 3), '0, '0, 0);
      wait_acked();
    end

    // idle up to the timestamp wrap, then packets across it
    while (cyc < 65500) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      pkt_both($urandom_range(0, 1), 1, 0, '0, '0, 0);
      wait_acked();
    end

    // reset in the middle of the checksum pass
    pkt_both(0, 1, 0, '0, '0, 0);
    exp_q.pop_back(); exp_rdy_q.pop_back(); exp_ovr_q.pop_back(); hold_q.pop_back();
    pushed--;
    f = compute_f();
    for (int k = 0; k < 100 && cyc < f + 10; k++) @(negedge clk);
    reset = 1;
    #1;
    check("abort_ready", data_ready, 1'b0);
    check("abort_bytes", pack_bytes(), 256'h0);
    check("abort_overrun", overrun, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (50) @(negedge clk);
    drv_ack = 1;
    @(negedge clk);
    drv_ack = 0;
    repeat (200) @(negedge clk);
    pkt_single(0, 1, 0);
    wait_acked();

    repeat (5) @(negedge clk);
    finish_now();
  end

endmodule
